adc128s_spi_model: RTL and testbench

Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style, "full channel" variant) used on the Segway board bench. It serves the four analog quantities the Segway reads: left load cell, right load cell, steering pot and battery. It is a SPI slave clocked on the system clock and talks to the Segway's A2D interface over SS_n/SCLK/MOSI/MISO.

---
 rtl/adc128s_spi_model_pkg.sv | 43 ++++
 rtl/adc128s_spi_model_spi_slave_shift.sv | 88 ++++++++
 rtl/adc128s_spi_model.sv | 73 +++++++
 tb/tb_adc128s_spi_model.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/adc128s_spi_model_pkg.sv
// ------------------------------------------------------------------------
// adc128s_spi_model_pkg : channel map and 16-bit SPI word layout  (rev 1.0)
// ------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package adc128s_spi_model_pkg;

  localparam logic [2:0] LFT_CH   = 3'd0;
  localparam logic [2:0] RGHT_CH  = 3'd4;
  localparam logic [2:0] STEER_CH = 3'd5;
  localparam logic [2:0] BATT_CH  = 3'd6;

  localparam int WORD_W    = 16;
  localparam int DATA_W    = 12;
  localparam int BIT_CNT_W = 5;

  localparam logic [BIT_CNT_W-1:0] FULL_CNT = 5'd16;
  localparam logic [BIT_CNT_W-1:0] CNT_ONE  = 5'd1;

  // Command word: channel address lives in bits [13:11].
  typedef struct packed {
    logic [1:0]  rsvd_hi;
    logic [2:0]  ch;
    logic [10:0] rsvd_lo;
  } cmd_word_t;

  // Response word: conversion result in bits [11:0].
  typedef struct packed {
    logic [3:0]        zero;
    logic [DATA_W-1:0] data;
  } rsp_word_t;

  function automatic rsp_word_t make_rsp(input logic [DATA_W-1:0] d);
    rsp_word_t w;
    w.zero = 4'h0;
    w.data = d;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc128s_spi_model_spi_slave_shift.sv
// ------------------------------------------------------------------------
// spi_slave_shift : synchronizers, edge detect, rx/tx shifters, bit count (rev 1.0)
// ------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_slave_shift
  import adc128s_spi_model_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  input  logic [WORD_W-1:0] tx_load_i,
  output logic              ss_fall_o,
  output logic              done_o,
  output logic [WORD_W-1:0] rx_o,
  output logic              miso_o
);

  // [0],[1] are the two synchronizer stages; [2] is the previous sample.
  logic [2:0]           ss_sync_q;
  logic [2:0]           sclk_sync_q;
  logic [1:0]           mosi_sync_q;
  logic [WORD_W-1:0]    tx_q, tx_d;
  logic [WORD_W-1:0]    rx_q, rx_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

  logic ss_low, ss_fall, ss_rise, sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], ss_n_i};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
    end
  end

  assign ss_low    = ~ss_sync_q[1];
  assign ss_fall   =  ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_rise   = ~ss_sync_q[2] &  ss_sync_q[1];
  assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
  assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];

  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    cnt_d = cnt_q;
    if (ss_fall) begin
      tx_d  = tx_load_i;
      cnt_d = '0;
    end else if (ss_low) begin
      if (sclk_rise && (cnt_q != FULL_CNT)) begin
        rx_d  = {rx_q[WORD_W-2:0], mosi_sync_q[1]};
        cnt_d = cnt_q + CNT_ONE;
      end
      // The leading fall of a transaction precedes any rise and must not shift.
      if (sclk_fall && (cnt_q != '0)) begin
        tx_d = {tx_q[WORD_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
    end
  end

  assign ss_fall_o = ss_fall;
  assign done_o    = ss_rise & (cnt_q == FULL_CNT);
  assign rx_o      = rx_q;
  assign miso_o    = ss_low & tx_q[WORD_W-1];

endmodule

`default_nettype wire

// File: rtl/adc128s_spi_model.sv
// ------------------------------------------------------------------------
// adc128s_spi_model : 8-ch 12-bit SPI A2D slave with pipelined channel read (rev 1.0)
// ------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adc128s_spi_model
  import adc128s_spi_model_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] ld_cell_lft,
  input  logic [DATA_W-1:0] ld_cell_rght,
  input  logic [DATA_W-1:0] steerPot,
  input  logic [DATA_W-1:0] batt
);

  logic [2:0]        pend_ch_q, pend_ch_d;
  logic [DATA_W-1:0] sel_val;
  logic [WORD_W-1:0] tx_load;
  logic [WORD_W-1:0] rx_word;
  logic              ss_fall;
  logic              done;
  cmd_word_t         cmd;
  logic              unused_rsvd;

  always_comb begin
    sel_val = '0;
    case (pend_ch_q)
      LFT_CH:   sel_val = ld_cell_lft;
      RGHT_CH:  sel_val = ld_cell_rght;
      STEER_CH: sel_val = steerPot;
      BATT_CH:  sel_val = batt;
      default:  sel_val = '0;
    endcase
  end

  assign tx_load = make_rsp(sel_val);

  spi_slave_shift u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n_i    (SS_n),
    .sclk_i    (SCLK),
    .mosi_i    (MOSI),
    .tx_load_i (tx_load),
    .ss_fall_o (ss_fall),
    .done_o    (done),
    .rx_o      (rx_word),
    .miso_o    (MISO)
  );

  assign cmd         = cmd_word_t'(rx_word);
  assign unused_rsvd = ^{cmd.rsvd_hi, cmd.rsvd_lo, ss_fall};

  // Only a complete 16-rise transaction advances the pipelined channel.
  always_comb begin
    pend_ch_d = pend_ch_q;
    if (done) pend_ch_d = cmd.ch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_ch_q <= 3'd0;
    else        pend_ch_q <= pend_ch_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_adc128s_spi_model.sv
// ------------------------------------------------------------------------
// tb_adc128s_spi_model : directed + random SPI transactions vs reference model (rev 1.0)
// ------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adc128s_spi_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [11:0] lft = 12'h0, rght = 12'h0, steer = 12'h0, batt = 12'h0;

  int          total = 0;
  int          passed = 0;
  logic [2:0]  model_pend = 3'd0;

  always #5 clk = ~clk;

  adc128s_spi_model dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .ld_cell_lft  (lft),
    .ld_cell_rght (rght),
    .steerPot     (steer),
    .batt         (batt)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  // Value the converter is expected to report for a given channel address.
  function automatic logic [11:0] ref_val(input logic [2:0] ch);
    if (ch == 3'd0) return lft;
    if (ch == 3'd4) return rght;
    if (ch == 3'd5) return steer;
    if (ch == 3'd6) return batt;
    return 12'h000;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Master side: SCLK period 8 clk, MISO captured just before each rise.
  task automatic xfer(input logic [15:0] cmd, input int nrise, input int chg_at,
                      input logic [11:0] chg_val, output logic [15:0] got);
    got = '0;
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      repeat (4) @(negedge clk);
      if (i < 16) got[15-i] = MISO;
      else        check("miso_past16", {15'b0, MISO}, 16'h0000);
      SCLK = 1'b1;
      if (i == chg_at) steer = chg_val;
      repeat (4) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [2:0] ch, input int nrise,
                     input int chg_at, input logic [11:0] chg_val);
    logic [15:0] exp, got, cmd;
    exp = {4'h0, ref_val(model_pend)};
    cmd = {2'($urandom), ch, 11'($urandom)};
    xfer(cmd, nrise, chg_at, chg_val, got);
    if (nrise >= 16) begin
      check(tag, got, exp);
      model_pend = ch;
    end
    check({tag, "_idle"}, {15'b0, MISO}, 16'h0000);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("reset_miso", {15'b0, MISO}, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    lft = 12'h121; rght = 12'h139;
    run("first_ch0", 3'd0, 16, -1, 12'h0);
    run("ch0_again", 3'd4, 16, -1, 12'h0);
    run("rght",      3'd5, 16, -1, 12'h0);
    steer = 12'hE00; batt = 12'hFFF;
    run("steer",     3'd6, 16, -1, 12'h0);
    run("batt",      3'd5, 16, -1, 12'h0);

    steer = 12'h800;
    run("steer_inflight", 3'd5, 16, 8, 12'h600);
    run("steer_new",      3'd2, 16, -1, 12'h0);
    run("unused_ch",      3'd0, 16, -1, 12'h0);

    run("abort",       3'd6, 8, -1, 12'h0);
    run("after_abort", 3'd4, 16, -1, 12'h0);
    run("overlength",  3'd0, 18, -1, 12'h0);
    run("after_over",  3'd5, 16, -1, 12'h0);

    // Reset in the middle of a transaction returning a steerPot word.
    steer = 12'hFFF; lft = 12'h3A5;
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b0; repeat (4) @(negedge clk);
      SCLK = 1'b1; repeat (4) @(negedge clk);
    end
    SCLK = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_miso", {15'b0, MISO}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("mid_reset_miso", {15'b0, MISO}, 16'h0000);
    model_pend = 3'd0;
    SS_n = 1'b1; SCLK = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run("post_reset", 3'd6, 16, -1, 12'h0);

    for (int k = 0; k < 20; k++) begin
      lft   = 12'($urandom);
      rght  = 12'($urandom);
      steer = 12'($urandom);
      batt  = 12'($urandom);
      if ($urandom_range(0, 4) == 0)
        run("rand_abort", 3'($urandom_range(0, 7)), $urandom_range(1, 15), -1, 12'h0);
      else
        run("rand", 3'($urandom_range(0, 7)), 16, -1, 12'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
